// File: rtl/rr_mux_arbiter4_pkg.sv
// rtl/rr_mux_arbiter4_pkg.sv - shared state encoding, requester indices and helpers for the arbiter
package rr_mux_arbiter4_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [1:0] REQ0 = 2'd0;
  localparam logic [1:0] REQ1 = 2'd1;
  localparam logic [1:0] REQ2 = 2'd2;
  localparam logic [1:0] REQ3 = 2'd3;

  // Encoded requester index to its one-hot grant vector.
  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    oh = 4'b0000;
    case (idx)
      REQ0: oh = 4'b0001;
      REQ1: oh = 4'b0010;
      REQ2: oh = 4'b0100;
      REQ3: oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter4_if.sv
// rtl/rr_mux_arbiter4_if.sv - request/data/grant bundle between requesters and the arbiter
interface rr_mux_arbiter4_if #(
  parameter int WIDTH = 32
);

  logic [3:0]       req;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [3:0]       grant;
  logic [1:0]       sel;
  logic             busy;
  logic             preempt;
  logic [WIDTH-1:0] data_out;

  // Requester side: raises requests and presents data, observes the grant.
  modport master (
    output req, d0, d1, d2, d3,
    input  grant, sel, busy, preempt, data_out
  );

  // Arbiter side.
  modport slave (
    input  req, d0, d1, d2, d3,
    output grant, sel, busy, preempt, data_out
  );

endinterface

// File: rtl/rr_mux_arbiter4_mux4.sv
// rtl/rr_mux_arbiter4_mux4.sv - plain 4:1 datapath mux primitive
module mux4 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);

  // Route the selected input straight through.
  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/rr_mux_arbiter4.sv
// rtl/rr_mux_arbiter4.sv - four-way round-robin arbiter with tenure limit sharing one datapath
module rr_mux_arbiter4
  import rr_mux_arbiter4_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input logic            clk,
  input logic            reset,
  rr_mux_arbiter4_if.slave bus
);

  // Last tenure cycle; with MAX_HOLD=0 the counter simply stays at zero.
  localparam logic [CNT_W-1:0] HOLD_TOP = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam bit               PREEMPT_EN = (MAX_HOLD != 0);

  state_t           state_q, state_nxt;
  logic [1:0]       owner_q, owner_nxt;
  logic [1:0]       last_q, last_nxt;
  logic [CNT_W-1:0] hold_q, hold_nxt;
  logic [3:0]       grant_q, grant_nxt;
  logic             busy_q, busy_nxt;
  logic             preempt_q, preempt_nxt;

  logic             win_found;
  logic [1:0]       win_idx;
  logic             others_pending;

  // Search starts just after `base` and wraps; `base` itself is looked at last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Round-robin winner and competitor detection from the sampled requests.
  always_comb begin
    {win_found, win_idx} = rr_pick(bus.req, last_q);
    others_pending       = |(bus.req & ~idx_to_onehot(owner_q));
  end

  // Next-state and next-output decision for the owner FSM.
  always_comb begin
    state_nxt   = state_q;
    owner_nxt   = owner_q;
    last_nxt    = last_q;
    hold_nxt    = hold_q;
    grant_nxt   = grant_q;
    busy_nxt    = busy_q;
    preempt_nxt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_nxt = ST_GRANT;
          owner_nxt = win_idx;
          last_nxt  = win_idx;
          hold_nxt  = '0;
          grant_nxt = idx_to_onehot(win_idx);
          busy_nxt  = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!bus.req[owner_q]) begin
          // Release wins over a coinciding timeout, so no preempt pulse here.
          if (win_found) begin
            owner_nxt = win_idx;
            last_nxt  = win_idx;
            hold_nxt  = '0;
            grant_nxt = idx_to_onehot(win_idx);
          end else begin
            state_nxt = ST_IDLE;
            hold_nxt  = '0;
            grant_nxt = 4'b0000;
            busy_nxt  = 1'b0;
          end
        end else if (PREEMPT_EN && hold_q == HOLD_TOP && others_pending) begin
          owner_nxt   = win_idx;
          last_nxt    = win_idx;
          hold_nxt    = '0;
          grant_nxt   = idx_to_onehot(win_idx);
          preempt_nxt = 1'b1;
        end else if (PREEMPT_EN && hold_q != HOLD_TOP) begin
          hold_nxt = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = 4'b0000;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset leaves requester 0 first in line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= REQ0;
      last_q    <= REQ3;
      hold_q    <= '0;
      grant_q   <= 4'b0000;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      owner_q   <= owner_nxt;
      last_q    <= last_nxt;
      hold_q    <= hold_nxt;
      grant_q   <= grant_nxt;
      busy_q    <= busy_nxt;
      preempt_q <= preempt_nxt;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.sel     = owner_q;
  assign bus.busy    = busy_q;
  assign bus.preempt = preempt_q;

  mux4 #(
    .WIDTH(WIDTH)
  ) u_mux4 (
    .d0 (bus.d0),
    .d1 (bus.d1),
    .d2 (bus.d2),
    .d3 (bus.d3),
    .sel(owner_q),
    .y  (bus.data_out)
  );

endmodule

// File: tb/tb_rr_mux_arbiter4.sv
// tb/tb_rr_mux_arbiter4.sv - scoreboard bench for rr_mux_arbiter4 with MAX_HOLD=8 and MAX_HOLD=0
module tb_rr_mux_arbiter4;

  logic clk;
  logic reset;

  rr_mux_arbiter4_if #(.WIDTH(32)) if8 ();
  rr_mux_arbiter4_if #(.WIDTH(32)) if0 ();

  rr_mux_arbiter4 #(.WIDTH(32), .MAX_HOLD(8), .CNT_W(4)) dut8 (
    .clk  (clk),
    .reset(reset),
    .bus  (if8.slave)
  );

  rr_mux_arbiter4 #(.WIDTH(32), .MAX_HOLD(0), .CNT_W(4)) dut0 (
    .clk  (clk),
    .reset(reset),
    .bus  (if0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit busy;
    int owner;
    int last;
    int hold;
    bit pre;
  } mst_t;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] sel;
    bit         chk_sel;
    logic       busy;
    logic       preempt;
  } exp_t;

  mst_t       m8, m0;
  exp_t       q8[$];
  exp_t       q0[$];
  logic [31:0] dcur [4];
  int         passed = 0;
  int         total  = 0;
  bit         done   = 1'b0;

  // Behavioural model: one arbitration decision per clock edge.
  function automatic mst_t model_step(input mst_t s, input logic [3:0] r, input int maxh, input bit rst);
    mst_t n;
    int   win;
    bit   others;
    n = s;
    n.pre = 1'b0;
    if (rst) begin
      n.busy = 1'b0; n.owner = 0; n.last = 3; n.hold = 0;
      return n;
    end
    win = -1;
    for (int k = 1; k <= 4; k++)
      if (win < 0 && r[(s.last + k) % 4]) win = (s.last + k) % 4;
    if (!s.busy) begin
      if (win >= 0) begin n.busy = 1'b1; n.owner = win; n.last = win; n.hold = 0; end
    end else if (!r[s.owner]) begin
      if (win >= 0) begin n.owner = win; n.last = win; n.hold = 0; end
      else begin n.busy = 1'b0; n.hold = 0; end
    end else begin
      others = 1'b0;
      for (int i = 0; i < 4; i++) if (i != s.owner && r[i]) others = 1'b1;
      if (maxh != 0 && s.hold == maxh - 1 && others) begin
        n.owner = win; n.last = win; n.hold = 0; n.pre = 1'b1;
      end else if (maxh != 0 && s.hold < maxh - 1) begin
        n.hold = s.hold + 1;
      end
    end
    return n;
  endfunction

  function automatic exp_t to_exp(input mst_t s, input bit rst);
    exp_t e;
    e.busy    = s.busy;
    e.grant   = s.busy ? 4'(1 << s.owner) : 4'b0000;
    e.sel     = 2'(s.owner);
    e.chk_sel = s.busy || rst;
    e.preempt = s.pre;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act === req_v) passed++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, req_v, $time);
  endtask

  // Drive one cycle of inputs, advance both models and queue the post-edge expectation.
  task automatic cycle(input logic [3:0] r, input bit rst);
    for (int i = 0; i < 4; i++) dcur[i] = $urandom;
    reset = rst;
    if8.req = r; if0.req = r;
    if8.d0 = dcur[0]; if8.d1 = dcur[1]; if8.d2 = dcur[2]; if8.d3 = dcur[3];
    if0.d0 = dcur[0]; if0.d1 = dcur[1]; if0.d2 = dcur[2]; if0.d3 = dcur[3];
    m8 = model_step(m8, r, 8, rst);
    m0 = model_step(m0, r, 0, rst);
    q8.push_back(to_exp(m8, rst));
    q0.push_back(to_exp(m0, rst));
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per DUT per cycle and compares mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        chk("h8_grant", 32'(if8.grant), 32'(e.grant));
        chk("h8_busy", 32'(if8.busy), 32'(e.busy));
        chk("h8_preempt", 32'(if8.preempt), 32'(e.preempt));
        if (e.chk_sel) begin
          chk("h8_sel", 32'(if8.sel), 32'(e.sel));
          chk("h8_data", if8.data_out, dcur[e.sel]);
        end
      end else if (!done) begin
        total++;
        $display("FAIL h8_queue actual=empty required=entry at %0t", $time);
      end
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("h0_grant", 32'(if0.grant), 32'(e.grant));
        chk("h0_busy", 32'(if0.busy), 32'(e.busy));
        chk("h0_preempt", 32'(if0.preempt), 32'(e.preempt));
        if (e.chk_sel) begin
          chk("h0_sel", 32'(if0.sel), 32'(e.sel));
          chk("h0_data", if0.data_out, dcur[e.sel]);
        end
      end else if (!done) begin
        total++;
        $display("FAIL h0_queue actual=empty required=entry at %0t", $time);
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized request patterns.
  initial begin
    logic [3:0] r;
    int         n;
    m8 = '{busy: 1'b0, owner: 0, last: 3, hold: 0, pre: 1'b0};
    m0 = m8;
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) cycle(4'b0001, 1'b0);
    for (int i = 0; i < 45; i++) cycle(4'b1111, 1'b0);
    n = 0;
    while (m8.owner != 2 && n < 40) begin cycle(4'b1111, 1'b0); n++; end
    for (int i = 0; i < 3; i++) cycle(4'b1011, 1'b0);
    cycle(4'b0000, 1'b0);
    for (int i = 0; i < 20; i++) cycle(4'b0010, 1'b0);
    n = 0;
    while (m8.owner != 2 && n < 40) begin cycle(4'b1111, 1'b0); n++; end
    cycle(4'b1111, 1'b1);
    for (int i = 0; i < 12; i++) cycle(4'b1111, 1'b0);
    cycle(4'b1110, 1'b0);
    cycle(4'b1110, 1'b0);
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      cycle(r, $urandom_range(0, 99) == 0);
    end
    done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter4.md
Name: rr_mux_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one WIDTH-bit datapath through the existing 4:1 mux primitive.
- Registers the owner, drives the mux select and a one-hot grant, and enforces a maximum tenure so no requester can starve the others.
- Used to share a single memory/IO write path between the CPU datapath and peripheral masters on the FPGA build.

Parameters:
- WIDTH, 32, data width of each requester input and of data_out
- MAX_HOLD, 8, maximum consecutive owned cycles before forced rotation when others wait; 0 = no preemption
- CNT_W, 4, hold counter width; must satisfy 2**CNT_W > MAX_HOLD

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req  input  4  per-requester request, level, bit i = requester i
- d0  input  WIDTH  requester 0 data
- d1  input  WIDTH  requester 1 data
- d2  input  WIDTH  requester 2 data
- d3  input  WIDTH  requester 3 data
- grant  output  4  registered one-hot grant, all-zero when idle
- sel  output  2  registered mux select, encoded owner index
- busy  output  1  registered, high while any grant is asserted
- preempt  output  1  registered one-cycle pulse on a timeout-forced rotation
- data_out  output  WIDTH  selected data; qualified by busy

Behaviour:
- Reset behaviour:
  - clk and reset are the only clock/reset; reset is synchronous and active-high.
  - On reset: state=IDLE, grant=0, sel=0, busy=0, preempt=0, hold_cnt=0, last=3, so requester 0 has top priority first.
  - Reset mid-tenure drops grant at that edge. The in-flight transfer is abandoned, with no completion cycle.
- Priority search: start at (last+1) mod 4 and wrap 3→0. The first set req bit wins.
- Arbitration is decided at the clock edge; grant, sel and busy change together. Latency from req rising (sampled) to grant is 1 cycle.
- State IDLE:
  - No req → stay.
  - Any req → GRANT with owner=winner, last=winner, hold_cnt=0.
- State GRANT, evaluated each edge in priority order:
  1. req[owner]=0:
     - If other reqs are pending, grant the next winner at the same edge (back-to-back, no idle bubble), with hold_cnt=0.
     - Otherwise go to IDLE with grant=0.
  2. MAX_HOLD≠0, hold_cnt=MAX_HOLD-1, and another req is pending: rotate to the next winner, hold_cnt=0, preempt=1 for one cycle.
  3. Otherwise keep the owner and increment hold_cnt. It saturates at MAX_HOLD-1 when no competitor is waiting, so the owner keeps the grant indefinitely while alone.
- Round-robin pointer: the search after a release or preempt excludes nobody. The previous owner is eligible, but it is searched last (last=previous owner).
- data_out is combinational from the mux: data_out = d[sel]. When busy=0 it is don't-care for consumers; it shows d0 after reset.
- Invariants:
  - grant is always one-hot or zero.
  - sel == index(grant) whenever busy=1.
  - busy == |grant.
- Simultaneous events: a release and a timeout in the same cycle are treated as a release (preempt stays 0). req bits that rise and fall entirely between edges are not seen.

Decomposition:
- Shared header arb_defs.vh: state encodings ST_IDLE=1'b0, ST_GRANT=1'b1; requester index constants REQ0..REQ3.
- The round-robin winner search goes in a function or combinational block inside this module.
- Sub-module: instantiate the existing mux4 (WIDTH passed through) for data_out, with sel driven from the registered owner. No other sub-modules.

Test Plan:
- Reset then req=0001 at cycle 2 → grant=0001, sel=0, busy=1 at cycle 3; data_out=d0.
- All four req held high with MAX_HOLD=8:
  - grants rotate 0→1→2→3→0, each held exactly 8 cycles;
  - preempt pulses 1 cycle at each rotation;
  - no cycle with grant=0.
- Owner 2 drops req while req=1011 → next edge grant=1000 (3 searched first after 2), no bubble, preempt=0.
- Single requester 1 held for 20 cycles with MAX_HOLD=8 → grant stays 0010 throughout, preempt never asserts, hold_cnt saturates at 7.
- Assert reset while grant=0100 and req=1111 → grant=0, busy=0 at that edge. After release, the first grant is 0001 (last reset to 3).
- MAX_HOLD=0 with req=1111 → requester 0 keeps the grant until its req drops, then grant=0010 on the next edge.
